// File: rtl/crc_checker.sv
// Serial CRC-8 receive checker: reseeds and runs the LFSR over each payload, then checks
// the appended CRC bits (LSB first) against the residue and reports a one-cycle verdict.
module crc_checker #(
    parameter int unsigned              DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]    SEED       = 8'hD8,
    parameter logic [DATA_WIDTH-1:0]    TAPS       = 8'b0100_0100
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  DATA_ACTIVE,
    input  logic                  DATA_IN,
    input  logic                  CRC_VALID,
    input  logic                  CRC_IN,
    output logic                  BUSY,
    output logic                  CHK_DONE,
    output logic                  CRC_OK,
    output logic                  CRC_ERR,
    output logic [DATA_WIDTH-1:0] CRC_RX
);

    localparam int unsigned IW = $clog2(DATA_WIDTH);
    localparam int unsigned CW = IW + 1;

    typedef enum logic [1:0] {StIdle, StData, StCrc, StReport} state_e;

    state_e                r_state, w_state_d;
    logic [DATA_WIDTH-1:0] r_lfsr, w_lfsr_d;
    logic [CW-1:0]         r_cnt, w_cnt_d;
    logic                  r_err, w_err_d;
    logic [DATA_WIDTH-1:0] r_rx, w_rx_d;
    logic                  r_busy, r_done, r_ok, r_bad;
    logic                  w_done_d, w_ok_d, w_bad_d;
    logic                  w_consume;
    logic [IW-1:0]         w_idx;

    function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] s,
                                                        input logic d);
        logic fb;
        fb = d ^ s[0];
        // Top stage takes fb; lower stages take the shifted bit XOR fb where tapped.
        return (s >> 1) ^ ({DATA_WIDTH{fb}} & {1'b1, TAPS[DATA_WIDTH-2:0]});
    endfunction

    assign w_idx = r_cnt[IW-1:0];

    always_comb begin
        w_state_d = r_state;
        w_lfsr_d  = r_lfsr;
        w_cnt_d   = r_cnt;
        w_err_d   = r_err;
        w_rx_d    = r_rx;
        w_ok_d    = r_ok;
        w_bad_d   = r_bad;
        w_done_d  = 1'b0;
        w_consume = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (DATA_ACTIVE) begin
                    w_state_d = StData;
                    w_lfsr_d  = lfsr_step(SEED, DATA_IN);
                    w_cnt_d   = '0;
                    w_err_d   = 1'b0;
                    w_ok_d    = 1'b0;
                    w_bad_d   = 1'b0;
                end
            end
            StData: begin
                if (DATA_ACTIVE) begin
                    w_lfsr_d = lfsr_step(r_lfsr, DATA_IN);
                end else begin
                    w_state_d = StCrc;
                    w_consume = CRC_VALID;
                end
            end
            StCrc: begin
                // Payload restarting before the CRC completes means a truncated frame.
                if (DATA_ACTIVE) begin
                    w_state_d = StReport;
                    w_err_d   = 1'b1;
                end else begin
                    w_consume = CRC_VALID;
                end
            end
            StReport: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        if (w_consume) begin
            w_err_d       = r_err | (CRC_IN ^ r_lfsr[0]);
            w_rx_d[w_idx] = CRC_IN;
            w_lfsr_d      = {1'b0, r_lfsr[DATA_WIDTH-1:1]};
            w_cnt_d       = r_cnt + CW'(1);
            if (r_cnt == CW'(DATA_WIDTH - 1)) begin
                w_state_d = StReport;
            end
        end

        if (w_state_d == StReport && r_state != StReport) begin
            w_done_d = 1'b1;
            w_ok_d   = ~w_err_d;
            w_bad_d  = w_err_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= StIdle;
            r_lfsr  <= SEED;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_rx    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ok    <= 1'b0;
            r_bad   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_lfsr  <= w_lfsr_d;
            r_cnt   <= w_cnt_d;
            r_err   <= w_err_d;
            r_rx    <= w_rx_d;
            r_busy  <= (w_state_d == StData) || (w_state_d == StCrc);
            r_done  <= w_done_d;
            r_ok    <= w_ok_d;
            r_bad   <= w_bad_d;
        end
    end

    assign BUSY     = r_busy;
    assign CHK_DONE = r_done;
    assign CRC_OK   = r_ok;
    assign CRC_ERR  = r_bad;
    assign CRC_RX   = r_rx;

endmodule

// File: tb/tb_crc_checker.sv
// Directed bench for crc_checker: good/corrupt/gapped/back-to-back/truncated frames and
// mid-frame reset, with expected CRCs computed by hand for SEED=D8, TAPS=0x44.
module tb_crc_checker;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       DATA_ACTIVE = 1'b0;
    logic       DATA_IN = 1'b0;
    logic       CRC_VALID = 1'b0;
    logic       CRC_IN = 1'b0;
    logic       BUSY, CHK_DONE, CRC_OK, CRC_ERR;
    logic [7:0] CRC_RX;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0;

    crc_checker dut (
        .CLK         (CLK),
        .RST         (RST),
        .DATA_ACTIVE (DATA_ACTIVE),
        .DATA_IN     (DATA_IN),
        .CRC_VALID   (CRC_VALID),
        .CRC_IN      (CRC_IN),
        .BUSY        (BUSY),
        .CHK_DONE    (CHK_DONE),
        .CRC_OK      (CRC_OK),
        .CRC_ERR     (CRC_ERR),
        .CRC_RX      (CRC_RX)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic da, input logic din, input logic cv, input logic cin);
        DATA_ACTIVE = da;
        DATA_IN     = din;
        CRC_VALID   = cv;
        CRC_IN      = cin;
        tick();
    endtask

    task automatic send_payload(input logic [7:0] bits);
        for (int i = 0; i < 8; i++) drive(1'b1, bits[i], 1'b0, 1'b0);
    endtask

    task automatic send_crc(input logic [7:0] crc, input int nbits, input int gap_after,
                            input int gap_len);
        for (int i = 0; i < nbits; i++) begin
            drive(1'b0, 1'b0, 1'b1, crc[i]);
            if (i == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    drive(1'b0, 1'b0, 1'b0, 1'b0);
                    check_eq("gap_no_done", CHK_DONE, 0);
                    check_eq("gap_busy", BUSY, 1);
                end
            end
        end
        DATA_ACTIVE = 1'b0;
        CRC_VALID   = 1'b0;
    endtask

    task automatic check_verdict(input string tag, input logic ok, input logic [7:0] rx);
        check_eq({tag, "_done"}, CHK_DONE, 1);
        check_eq({tag, "_ok"}, CRC_OK, ok);
        check_eq({tag, "_err"}, CRC_ERR, !ok);
        check_eq({tag, "_rx"}, CRC_RX, rx);
    endtask

    initial begin
        #12;
        check_eq("rst_busy", BUSY, 0);
        check_eq("rst_done", CHK_DONE, 0);
        check_eq("rst_ok", CRC_OK, 0);
        check_eq("rst_err", CRC_ERR, 0);
        check_eq("rst_rx", CRC_RX, 0);
        RST = 1'b1;
        tick();

        // Good frame: 8 zero bits -> residue 0x14.
        send_payload(8'h00);
        check_eq("good_busy", BUSY, 1);
        t0 = cyc;
        send_crc(8'h14, 8, -1, 0);
        check_eq("good_latency", cyc - t0, 8);
        check_verdict("good", 1'b1, 8'h14);
        tick();
        check_eq("good_done_pulse", CHK_DONE, 0);
        check_eq("good_ok_held", CRC_OK, 1);
        check_eq("good_idle_busy", BUSY, 0);

        // Back-to-back second frame; CRC_OK clears on its first payload bit.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("b2b_ok_clear", CRC_OK, 0);
        for (int i = 1; i < 8; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        send_crc(8'h14, 8, -1, 0);
        check_verdict("b2b", 1'b1, 8'h14);
        tick();

        // Corrupt CRC.
        send_payload(8'h00);
        send_crc(8'h15, 8, -1, 0);
        check_verdict("bad", 1'b0, 8'h15);
        tick();

        // Payload with first bit 1 -> residue 0xBF.
        send_payload(8'h01);
        send_crc(8'hBF, 8, -1, 0);
        check_verdict("pay01", 1'b1, 8'hBF);
        tick();

        // Gapped CRC: 3 idle cycles after bit 3.
        send_payload(8'h00);
        t0 = cyc;
        send_crc(8'h14, 8, 3, 3);
        check_eq("gap_latency", cyc - t0, 11);
        check_verdict("gap", 1'b1, 8'h14);
        tick();

        // Truncation after 4 CRC bits.
        send_payload(8'h00);
        send_crc(8'h14, 4, -1, 0);
        check_eq("trunc_wait_done", CHK_DONE, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("trunc_done", CHK_DONE, 1);
        check_eq("trunc_err", CRC_ERR, 1);
        check_eq("trunc_ok", CRC_OK, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("trunc_single_done", CHK_DONE, 0);
        check_eq("trunc_idle", BUSY, 0);
        check_eq("trunc_err_held", CRC_ERR, 1);
        tick();
        check_eq("trunc_no_new_frame", BUSY, 0);

        // Reset mid-CRC after 5 bits.
        send_payload(8'h00);
        send_crc(8'h14, 5, -1, 0);
        #2;
        RST = 1'b0;
        #1;
        check_eq("mrst_busy", BUSY, 0);
        check_eq("mrst_done", CHK_DONE, 0);
        check_eq("mrst_ok", CRC_OK, 0);
        check_eq("mrst_err", CRC_ERR, 0);
        check_eq("mrst_rx", CRC_RX, 0);
        tick();
        tick();
        check_eq("mrst_hold_done", CHK_DONE, 0);
        RST = 1'b1;
        tick();
        check_eq("mrst_after_done", CHK_DONE, 0);
        send_payload(8'h00);
        send_crc(8'h14, 8, -1, 0);
        check_verdict("post_rst", 1'b1, 8'h14);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crc_checker.md
Name: crc_checker

Overview:
- Serial CRC-8 receive-side checker; the far end of the team's serial CRC generator link.
- Recomputes the LFSR over the incoming data bits, then compares the appended CRC bits, LSB first, against the residue.
- Reports pass/fail with a one-cycle done strobe.
- Sits in the receive path after the bit deserialiser and before the frame-accept logic.

Parameters:
- DATA_WIDTH, 8: LFSR and CRC width, and the number of CRC bits per frame.
- SEED, 8'hD8: LFSR value at the start of each frame.
- TAPS, 8'b0100_0100: feedback tap mask; bit N set means stage N receives LFSR[N+1]^fb.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- DATA_ACTIVE  in  1  high while DATA_IN carries a payload bit; one bit consumed per high cycle.
- DATA_IN  in  1  serial payload bit.
- CRC_VALID  in  1  high while CRC_IN carries a CRC bit.
- CRC_IN  in  1  serial received CRC bit, LSB first.
- BUSY  out  1  high in DATA or CRC state.
- CHK_DONE  out  1  one-cycle pulse when the verdict is produced.
- CRC_OK  out  1  frame passed; held until the next frame starts.
- CRC_ERR  out  1  frame failed (mismatch or truncation); held until the next frame starts.
- CRC_RX  out  DATA_WIDTH  received CRC byte assembled LSB first; valid when CHK_DONE is high.

Behaviour:
- Reset (RST low, async):
  - state=IDLE, LFSR=SEED, bit count=0, error accumulator=0, CRC_RX=0.
  - BUSY, CHK_DONE, CRC_OK and CRC_ERR all 0.
- LFSR step per payload bit:
  - fb = DATA_IN ^ LFSR[0]; LFSR[DATA_WIDTH-1] <= fb.
  - For N < DATA_WIDTH-1: LFSR[N] <= LFSR[N+1] ^ (TAPS[N] & fb).
- IDLE:
  - DATA_ACTIVE=1 → go to DATA and clear CRC_OK, CRC_ERR, count and error accumulator.
  - In the same cycle, the LFSR takes step(SEED, DATA_IN). Reseed is per frame; there is no dependence on the previous frame.
  - CRC_VALID is ignored in IDLE.
- DATA:
  - DATA_ACTIVE=1 → LFSR step; CRC_VALID is ignored when both are high.
  - DATA_ACTIVE=0 → go to CRC. If CRC_VALID=1 in that same cycle, consume it as CRC bit 0 (rules below).
- CRC state, CRC bit consume (on each CRC_VALID=1 while DATA_ACTIVE=0):
  - err |= CRC_IN ^ LFSR[0].
  - CRC_RX[count] <= CRC_IN.
  - LFSR <= {1'b0, LFSR[DATA_WIDTH-1:1]}.
  - count++.
- CRC state, other cases:
  - CRC_VALID=0 → hold all state; gaps of any length are allowed.
  - Consume with count==DATA_WIDTH-1 → go to REPORT.
  - DATA_ACTIVE=1 before all DATA_WIDTH CRC bits arrive → truncation: go to REPORT with err forced to 1. That DATA_IN bit is discarded and does not start a new frame.
- REPORT (exactly one cycle):
  - CHK_DONE=1; CRC_OK=~err; CRC_ERR=err; CRC_RX stable.
  - Next state is IDLE.
  - A DATA_ACTIVE high during REPORT is ignored; frames need at least one idle cycle between them.
- Output timing:
  - CHK_DONE rises the cycle after the last CRC bit is sampled.
  - CRC_OK and CRC_ERR are registered, mutually exclusive and never both 1.
  - BUSY is a registered decode of the state.
- Reset mid-frame: returns to the reset values immediately; the partial frame produces no CHK_DONE.
- Widths: count is $clog2(DATA_WIDTH)+1 bits and never wraps within a frame. Payload length is unbounded.

Test Plan:
- Good frame: seed D8, payload 8 zero bits, then CRC bits 0,0,1,0,1,0,0,0 (0x14 LSB first) → CHK_DONE pulse, CRC_OK=1, CRC_ERR=0, CRC_RX=8'h14.
- Corrupt CRC: same payload, CRC 0x15 → CRC_ERR=1, CRC_OK=0, CRC_RX=8'h15.
- Gapped CRC: same as the good frame with 3 idle cycles between CRC bits 3 and 4 → same pass result; CHK_DONE arrives 3 cycles later.
- Back-to-back: good frame, one idle cycle, second 0x00 frame with 0x14 → both pass, which proves the per-frame reseed. CRC_OK clears on the second frame's first DATA_ACTIVE.
- Truncation: 0x00 payload, 4 CRC bits, then DATA_ACTIVE=1 → CRC_ERR=1, one CHK_DONE, then IDLE.
- Reset mid-CRC: RST low after 5 CRC bits → all outputs 0 immediately, no CHK_DONE; the next good frame passes.
